// File: rtl/decode_stage.sv
// RV32I/RV64I decode stage: main decoder, register file, I/S/B/U immediates,
// load-use detection and ID/EX register. Define ID_WB_BYPASS_EN for write-first reads.
module decode_stage #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NUM_REGS = 32,
  localparam int unsigned REG_AW  = $clog2(NUM_REGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_id_valid,
  input  logic [31:0]       if_id_instr,
  input  logic [XLEN-1:0]   if_id_pc,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_flush,
  output logic              hazard_stall,
  output logic              id_ex_valid,
  output logic [XLEN-1:0]   id_ex_pc,
  output logic [XLEN-1:0]   id_ex_rs1_data,
  output logic [XLEN-1:0]   id_ex_rs2_data,
  output logic [XLEN-1:0]   id_ex_imm,
  output logic [REG_AW-1:0] id_ex_rs1,
  output logic [REG_AW-1:0] id_ex_rs2,
  output logic [REG_AW-1:0] id_ex_rd,
  output logic [3:0]        id_ex_funct,
  output logic [1:0]        id_ex_aluop,
  output logic              id_ex_alusrc,
  output logic              id_ex_memread,
  output logic              id_ex_memwrite,
  output logic              id_ex_regwrite,
  output logic              id_ex_memtoreg,
  output logic              id_ex_branch,
  output logic              id_ex_illegal
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111
  } opcode_e;

  opcode_e            opcode;
  logic [REG_AW-1:0]  rs1_f, rs2_f, rd_f;
  logic [1:0]         dec_aluop;
  logic               dec_alusrc, dec_memread, dec_memwrite, dec_regwrite;
  logic               dec_memtoreg, dec_branch, dec_illegal;
  logic               use_rs1, use_rs2, is_lui;
  logic signed [31:0] imm32;
  logic [XLEN-1:0]    rs1_data, rs2_data;
  logic [XLEN-1:0]    regs [NUM_REGS];
  logic               load_use, bubble;

  assign opcode = opcode_e'(if_id_instr[6:0]);
  assign rd_f   = if_id_instr[7 +: REG_AW];
  assign rs1_f  = if_id_instr[15 +: REG_AW];
  assign rs2_f  = if_id_instr[20 +: REG_AW];

  always_comb begin
    dec_aluop    = 2'b00;
    dec_alusrc   = 1'b0;
    dec_memread  = 1'b0;
    dec_memwrite = 1'b0;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_branch   = 1'b0;
    dec_illegal  = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    is_lui       = 1'b0;
    imm32        = '0;
    case (opcode)
      OP_R: begin
        dec_aluop    = 2'b10;
        dec_regwrite = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OP_IALU: begin
        dec_aluop    = 2'b11;
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        use_rs1      = 1'b1;
        imm32        = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
      end
      OP_LOAD: begin
        dec_alusrc   = 1'b1;
        dec_memread  = 1'b1;
        dec_regwrite = 1'b1;
        dec_memtoreg = 1'b1;
        use_rs1      = 1'b1;
        imm32        = {{20{if_id_instr[31]}}, if_id_instr[31:20]};
      end
      OP_STORE: begin
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        imm32        = {{20{if_id_instr[31]}}, if_id_instr[31:25], if_id_instr[11:7]};
      end
      OP_BRANCH: begin
        dec_aluop    = 2'b01;
        dec_branch   = 1'b1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
        imm32        = {{19{if_id_instr[31]}}, if_id_instr[31], if_id_instr[7],
                        if_id_instr[30:25], if_id_instr[11:8], 1'b0};
      end
      OP_LUI: begin
        dec_alusrc   = 1'b1;
        dec_regwrite = 1'b1;
        is_lui       = 1'b1;
        imm32        = {if_id_instr[31:12], 12'b0};
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // x0 and LUI's rs1 are forced to zero after any write-first bypass.
  always_comb begin
    rs1_data = regs[rs1_f];
    rs2_data = regs[rs2_f];
`ifdef ID_WB_BYPASS_EN
    if (wb_regwrite && (wb_rd == rs1_f)) rs1_data = wb_data;
    if (wb_regwrite && (wb_rd == rs2_f)) rs2_data = wb_data;
`endif
    if ((rs1_f == '0) || is_lui) rs1_data = '0;
    if (rs2_f == '0)             rs2_data = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wb_regwrite && (wb_rd != '0)) begin
      regs[wb_rd] <= wb_data;
    end
  end

  assign load_use = id_ex_valid && id_ex_memread && (id_ex_rd != '0) && if_id_valid &&
                    ((use_rs1 && (id_ex_rd == rs1_f)) || (use_rs2 && (id_ex_rd == rs2_f)));
  assign hazard_stall = load_use && !ex_flush;
  assign bubble       = !if_id_valid || ex_flush || hazard_stall;

  always_ff @(posedge clock) begin
    if (reset) begin
      id_ex_valid    <= 1'b0;
      id_ex_pc       <= '0;
      id_ex_rs1_data <= '0;
      id_ex_rs2_data <= '0;
      id_ex_imm      <= '0;
      id_ex_rs1      <= '0;
      id_ex_rs2      <= '0;
      id_ex_rd       <= '0;
      id_ex_funct    <= '0;
      id_ex_aluop    <= '0;
      id_ex_alusrc   <= 1'b0;
      id_ex_memread  <= 1'b0;
      id_ex_memwrite <= 1'b0;
      id_ex_regwrite <= 1'b0;
      id_ex_memtoreg <= 1'b0;
      id_ex_branch   <= 1'b0;
      id_ex_illegal  <= 1'b0;
    end else begin
      id_ex_pc       <= if_id_pc;
      id_ex_rs1_data <= rs1_data;
      id_ex_rs2_data <= rs2_data;
      id_ex_imm      <= XLEN'(imm32);
      id_ex_rs1      <= is_lui ? '0 : rs1_f;
      id_ex_rs2      <= rs2_f;
      id_ex_rd       <= rd_f;
      id_ex_funct    <= {if_id_instr[30], if_id_instr[14:12]};
      if (bubble) begin
        id_ex_valid    <= 1'b0;
        id_ex_aluop    <= '0;
        id_ex_alusrc   <= 1'b0;
        id_ex_memread  <= 1'b0;
        id_ex_memwrite <= 1'b0;
        id_ex_regwrite <= 1'b0;
        id_ex_memtoreg <= 1'b0;
        id_ex_branch   <= 1'b0;
        id_ex_illegal  <= 1'b0;
      end else begin
        id_ex_valid    <= 1'b1;
        id_ex_aluop    <= dec_aluop;
        id_ex_alusrc   <= dec_alusrc;
        id_ex_memread  <= dec_memread;
        id_ex_memwrite <= dec_memwrite;
        id_ex_regwrite <= dec_regwrite;
        id_ex_memtoreg <= dec_memtoreg;
        id_ex_branch   <= dec_branch;
        id_ex_illegal  <= dec_illegal;
      end
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a 32-bit instance carries every scenario,
// a 64-bit instance checks immediate sign extension to XLEN.
module tb_decode_stage;

  localparam logic [6:0] C_R   = 7'b0001000; // {alusrc,memread,memwrite,regwrite,memtoreg,branch,illegal}
  localparam logic [6:0] C_I   = 7'b1001000;
  localparam logic [6:0] C_LD  = 7'b1101100;
  localparam logic [6:0] C_ST  = 7'b1010000;
  localparam logic [6:0] C_BR  = 7'b0000010;
  localparam logic [6:0] C_LUI = 7'b1001000;
  localparam logic [6:0] C_ILL = 7'b0000001;

  typedef struct {
    logic [95:0] tag;
    logic        valid;
    logic [1:0]  aluop;
    logic [6:0]  ctl;
    logic [63:0] pc, d1, d2, imm;
    logic [4:0]  r1, r2, rd;
    logic [3:0]  funct;
    bit          chk_data, chk_imm;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        if_id_valid = 1'b0;
  logic [31:0] instr = '0;
  logic [31:0] pc = '0;
  logic        wb_regwrite = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_flush = 1'b0;

  logic        hazard_stall, id_ex_valid, id_ex_alusrc, id_ex_memread, id_ex_memwrite;
  logic        id_ex_regwrite, id_ex_memtoreg, id_ex_branch, id_ex_illegal;
  logic [31:0] id_ex_pc, id_ex_rs1_data, id_ex_rs2_data, id_ex_imm;
  logic [4:0]  id_ex_rs1, id_ex_rs2, id_ex_rd;
  logic [3:0]  id_ex_funct;
  logic [1:0]  id_ex_aluop;

  logic        h64, v64, alusrc64, memread64, memwrite64, regwrite64, memtoreg64, branch64, illegal64;
  logic [63:0] pc64, rs1d64, rs2d64, imm64;
  logic [4:0]  rs1_64, rs2_64, rd64;
  logic [3:0]  funct64;
  logic [1:0]  aluop64;

  exp_t q[$];
  exp_t q64[$];
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  decode_stage #(.XLEN(32), .NUM_REGS(32)) dut (
    .clock(clock), .reset(reset), .if_id_valid(if_id_valid), .if_id_instr(instr),
    .if_id_pc(pc), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
    .ex_flush(ex_flush), .hazard_stall(hazard_stall), .id_ex_valid(id_ex_valid),
    .id_ex_pc(id_ex_pc), .id_ex_rs1_data(id_ex_rs1_data), .id_ex_rs2_data(id_ex_rs2_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs1(id_ex_rs1), .id_ex_rs2(id_ex_rs2), .id_ex_rd(id_ex_rd),
    .id_ex_funct(id_ex_funct), .id_ex_aluop(id_ex_aluop), .id_ex_alusrc(id_ex_alusrc),
    .id_ex_memread(id_ex_memread), .id_ex_memwrite(id_ex_memwrite),
    .id_ex_regwrite(id_ex_regwrite), .id_ex_memtoreg(id_ex_memtoreg),
    .id_ex_branch(id_ex_branch), .id_ex_illegal(id_ex_illegal)
  );

  decode_stage #(.XLEN(64), .NUM_REGS(32)) dut64 (
    .clock(clock), .reset(reset), .if_id_valid(if_id_valid), .if_id_instr(instr),
    .if_id_pc(64'(pc)), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(64'(wb_data)),
    .ex_flush(ex_flush), .hazard_stall(h64), .id_ex_valid(v64),
    .id_ex_pc(pc64), .id_ex_rs1_data(rs1d64), .id_ex_rs2_data(rs2d64),
    .id_ex_imm(imm64), .id_ex_rs1(rs1_64), .id_ex_rs2(rs2_64), .id_ex_rd(rd64),
    .id_ex_funct(funct64), .id_ex_aluop(aluop64), .id_ex_alusrc(alusrc64),
    .id_ex_memread(memread64), .id_ex_memwrite(memwrite64),
    .id_ex_regwrite(regwrite64), .id_ex_memtoreg(memtoreg64),
    .id_ex_branch(branch64), .id_ex_illegal(illegal64)
  );

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, input logic [4:0] rs1,
                                        input logic [4:0] rd);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic exp_t mk(input logic [95:0] tag, input logic [63:0] p, input logic [63:0] d1,
                              input logic [63:0] d2, input logic [63:0] imm, input logic [4:0] r1,
                              input logic [4:0] r2, input logic [4:0] rd, input logic [3:0] f,
                              input logic [1:0] aluop, input logic [6:0] ctl, input bit chk_imm);
    exp_t e;
    e.tag = tag; e.valid = 1'b1; e.aluop = aluop; e.ctl = ctl;
    e.pc = p; e.d1 = d1; e.d2 = d2; e.imm = imm;
    e.r1 = r1; e.r2 = r2; e.rd = rd; e.funct = f;
    e.chk_data = 1'b1; e.chk_imm = chk_imm;
    return e;
  endfunction

  function automatic exp_t bubble(input logic [95:0] tag, input bit all_zero);
    exp_t e;
    e = mk(tag, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, all_zero);
    e.valid = 1'b0;
    e.chk_data = all_zero;
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p);
    if_id_valid = v;
    instr = ins;
    pc = p;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_regwrite = we;
    wb_rd = r;
    wb_data = d;
  endtask

  // Each edge retires at most one expectation per queue, pushed in the cycle before.
  exp_t me, me64;
  bit   mhas, mhas64;
  always @(posedge clock) begin
    mhas = (q.size() != 0);
    if (mhas) me = q.pop_front();
    mhas64 = (q64.size() != 0);
    if (mhas64) me64 = q64.pop_front();
    #2;
    if (mhas) begin
      vectors++;
      if ({id_ex_valid, id_ex_aluop, id_ex_alusrc, id_ex_memread, id_ex_memwrite, id_ex_regwrite,
           id_ex_memtoreg, id_ex_branch, id_ex_illegal} !== {me.valid, me.aluop, me.ctl}) begin
        miscompares++;
        $display("FAIL %0s ctrl: got %b want %b", me.tag, {id_ex_valid, id_ex_aluop, id_ex_alusrc,
                 id_ex_memread, id_ex_memwrite, id_ex_regwrite, id_ex_memtoreg, id_ex_branch,
                 id_ex_illegal}, {me.valid, me.aluop, me.ctl});
      end
      if (me.chk_data) begin
        vectors++;
        if ({64'(id_ex_pc), 64'(id_ex_rs1_data), 64'(id_ex_rs2_data)} !== {me.pc, me.d1, me.d2}) begin
          miscompares++;
          $display("FAIL %0s pc/rs1/rs2 data: got %h %h %h want %h %h %h", me.tag, id_ex_pc,
                   id_ex_rs1_data, id_ex_rs2_data, me.pc, me.d1, me.d2);
        end
        vectors++;
        if ({id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct} !== {me.r1, me.r2, me.rd, me.funct}) begin
          miscompares++;
          $display("FAIL %0s rs1/rs2/rd/funct: got %0d %0d %0d %h want %0d %0d %0d %h", me.tag,
                   id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_funct, me.r1, me.r2, me.rd, me.funct);
        end
      end
      if (me.chk_imm) begin
        vectors++;
        if (64'(id_ex_imm) !== me.imm) begin
          miscompares++;
          $display("FAIL %0s imm: got %h want %h", me.tag, id_ex_imm, me.imm);
        end
      end
    end
    if (mhas64) begin
      vectors++;
      if ({v64, aluop64, alusrc64, memread64, memwrite64, regwrite64, memtoreg64, branch64,
           illegal64} !== {me64.valid, me64.aluop, me64.ctl}) begin
        miscompares++;
        $display("FAIL %0s ctrl64: got %b want %b", me64.tag, {v64, aluop64, alusrc64, memread64,
                 memwrite64, regwrite64, memtoreg64, branch64, illegal64}, {me64.valid, me64.aluop, me64.ctl});
      end
      vectors++;
      if ({pc64, rs1d64, rs2d64, imm64, rs1_64, rs2_64, rd64, funct64} !==
          {me64.pc, me64.d1, me64.d2, me64.imm, me64.r1, me64.r2, me64.rd, me64.funct}) begin
        miscompares++;
        $display("FAIL %0s data64: got pc %h rs1d %h imm %h rs1 %0d rd %0d want pc %h rs1d %h imm %h rs1 %0d rd %0d",
                 me64.tag, pc64, rs1d64, imm64, rs1_64, rd64, me64.pc, me64.d1, me64.imm, me64.r1, me64.rd);
      end
    end
  end

  task automatic check_stall(input logic [95:0] tag, input logic want);
    #1;
    vectors++;
    if (hazard_stall !== want) begin
      miscompares++;
      $display("FAIL %0s hazard_stall: got %b want %b", tag, hazard_stall, want);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b1, enc_r(7'd0, 5'd2, 5'd1, 5'd7), 32'h40);
    q.push_back(bubble("reset0", 1'b1));
    tick();
    q.push_back(bubble("reset1", 1'b1));
    tick();
    reset = 1'b0;
    drive(1'b0, '0, '0);
    check_stall("post_reset", 1'b0);
    for (int i = 1; i < 32; i++) begin
      drive(1'b1, enc_r(7'd0, 5'(i), 5'(i), 5'd0), 32'h1000 + 32'(4 * i));
      q.push_back(mk("read_zero", 64'(32'h1000 + 32'(4 * i)), '0, '0, '0, 5'(i), 5'(i), 5'd0,
                     4'h0, 2'b10, C_R, 1'b0));
      tick();
    end
  endtask

  task automatic test_add();
    drive(1'b0, '0, '0);
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    q.push_back(bubble("wb_x5", 1'b0));
    tick();
    set_wb(1'b0, '0, '0);
    drive(1'b1, enc_r(7'd0, 5'd0, 5'd5, 5'd7), 32'h200);
    q.push_back(mk("add_x7", 64'h200, 64'hDEADBEEF, '0, '0, 5'd5, 5'd0, 5'd7, 4'h0, 2'b10, C_R, 1'b0));
    tick();
    drive(1'b1, enc_r(7'b0100000, 5'd5, 5'd5, 5'd10), 32'h204);
    q.push_back(mk("sub_x10", 64'h204, 64'hDEADBEEF, 64'hDEADBEEF, '0, 5'd5, 5'd5, 5'd10, 4'h8,
                   2'b10, C_R, 1'b0));
    tick();
    drive(1'b1, enc_i(12'hFFF, 5'd5, 3'b000, 5'd11, 7'b0010011), 32'h208);
    q.push_back(mk("addi_m1", 64'h208, 64'hDEADBEEF, '0, 64'hFFFFFFFF, 5'd5, 5'd31, 5'd11, 4'h8,
                   2'b11, C_I, 1'b1));
    tick();
  endtask

  task automatic test_load_use();
    drive(1'b0, '0, '0);
    set_wb(1'b1, 5'd1, 32'h100);
    q.push_back(bubble("wb_x1", 1'b0));
    tick();
    set_wb(1'b1, 5'd2, 32'h22);
    q.push_back(bubble("wb_x2", 1'b0));
    tick();
    set_wb(1'b0, '0, '0);
    drive(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'h300);
    q.push_back(mk("lw_x6", 64'h300, 64'h100, '0, '0, 5'd1, 5'd0, 5'd6, 4'h2, 2'b00, C_LD, 1'b1));
    tick();
    drive(1'b1, enc_r(7'd0, 5'd2, 5'd6, 5'd8), 32'h304);
    check_stall("lu_stall", 1'b1);
    q.push_back(bubble("lu_bubble", 1'b0));
    tick();
    check_stall("lu_release", 1'b0);
    q.push_back(mk("lu_add", 64'h304, '0, 64'h22, '0, 5'd6, 5'd2, 5'd8, 4'h0, 2'b10, C_R, 1'b0));
    tick();
    drive(1'b1, enc_i(12'd4, 5'd1, 3'b010, 5'd0, 7'b0000011), 32'h308);
    q.push_back(mk("lw_x0", 64'h308, 64'h100, '0, 64'h4, 5'd1, 5'd4, 5'd0, 4'h2, 2'b00, C_LD, 1'b1));
    tick();
    drive(1'b1, enc_r(7'd0, 5'd0, 5'd0, 5'd9), 32'h30C);
    check_stall("rd0_nostall", 1'b0);
    q.push_back(mk("add_x9", 64'h30C, '0, '0, '0, 5'd0, 5'd0, 5'd9, 4'h0, 2'b10, C_R, 1'b0));
    tick();
    drive(1'b1, enc_i(12'd8, 5'd2, 3'b010, 5'd6, 7'b0000011), 32'h310);
    q.push_back(mk("lw_x6b", 64'h310, 64'h22, '0, 64'h8, 5'd2, 5'd8, 5'd6, 4'h2, 2'b00, C_LD, 1'b1));
    tick();
    drive(1'b1, enc_s(12'd0, 5'd6, 5'd1), 32'h314);
    check_stall("st_stall", 1'b1);
    q.push_back(bubble("st_bubble", 1'b0));
    tick();
    check_stall("st_release", 1'b0);
    q.push_back(mk("sw_x6", 64'h314, 64'h100, '0, '0, 5'd1, 5'd6, 5'd0, 4'h2, 2'b00, C_ST, 1'b1));
    tick();
    drive(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd20, 7'b0000011), 32'h318);
    set_wb(1'b1, 5'd20, 32'h77);
    q.push_back(mk("lw_x20", 64'h318, 64'h100, '0, '0, 5'd1, 5'd0, 5'd20, 4'h2, 2'b00, C_LD, 1'b1));
    tick();
    set_wb(1'b0, '0, '0);
    drive(1'b1, {20'h800A5, 5'd3, 7'b0110111}, 32'h31C);
    check_stall("lui_nostall", 1'b0);
    q.push_back(mk("lui_a5", 64'h31C, '0, '0, 64'h800A5000, 5'd0, 5'd0, 5'd3, 4'h5, 2'b00, C_LUI, 1'b1));
    q64.push_back(mk("lui_a5_64", 64'h31C, '0, '0, 64'hFFFFFFFF800A5000, 5'd0, 5'd0, 5'd3, 4'h5,
                     2'b00, C_LUI, 1'b1));
    tick();
  endtask

  task automatic test_branch_flush();
    drive(1'b1, enc_b(13'h1FF8, 5'd2, 5'd1), 32'h400);
    q.push_back(mk("beq_m8", 64'h400, 64'h100, 64'h22, 64'hFFFFFFF8, 5'd1, 5'd2, 5'd25, 4'h8,
                   2'b01, C_BR, 1'b1));
    tick();
    drive(1'b1, enc_r(7'd0, 5'd2, 5'd1, 5'd8), 32'h404);
    ex_flush = 1'b1;
    q.push_back(bubble("flush", 1'b0));
    tick();
    ex_flush = 1'b0;
    drive(1'b1, enc_i(12'd0, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'h410);
    q.push_back(mk("lw_x6c", 64'h410, 64'h100, '0, '0, 5'd1, 5'd0, 5'd6, 4'h2, 2'b00, C_LD, 1'b1));
    tick();
    drive(1'b1, enc_r(7'd0, 5'd2, 5'd6, 5'd8), 32'h414);
    ex_flush = 1'b1;
    check_stall("flush_over_stall", 1'b0);
    q.push_back(bubble("flush_lu", 1'b0));
    tick();
    ex_flush = 1'b0;
    check_stall("after_flush", 1'b0);
    q.push_back(mk("add_refetch", 64'h414, '0, 64'h22, '0, 5'd6, 5'd2, 5'd8, 4'h0, 2'b10, C_R, 1'b0));
    tick();
    drive(1'b0, enc_i(12'd0, 5'd1, 3'b010, 5'd6, 7'b0000011), 32'h418);
    q.push_back(bubble("invalid_in", 1'b0));
    tick();
  endtask

  task automatic test_bypass();
    logic [31:0] same_cycle;
`ifdef ID_WB_BYPASS_EN
    same_cycle = 32'h1234;
`else
    same_cycle = 32'h5555;
`endif
    drive(1'b0, '0, '0);
    set_wb(1'b1, 5'd9, 32'h5555);
    q.push_back(bubble("wb_x9_old", 1'b0));
    tick();
    set_wb(1'b1, 5'd9, 32'h1234);
    drive(1'b1, enc_r(7'd0, 5'd9, 5'd9, 5'd12), 32'h500);
    q.push_back(mk("rd_during_wb", 64'h500, 64'(same_cycle), 64'(same_cycle), '0, 5'd9, 5'd9, 5'd12,
                   4'h0, 2'b10, C_R, 1'b0));
    tick();
    set_wb(1'b0, '0, '0);
    drive(1'b1, enc_r(7'd0, 5'd0, 5'd9, 5'd13), 32'h504);
    q.push_back(mk("rd_after_wb", 64'h504, 64'h1234, '0, '0, 5'd9, 5'd0, 5'd13, 4'h0, 2'b10, C_R, 1'b0));
    tick();
    set_wb(1'b1, 5'd0, 32'hFFFFFFFF);
    drive(1'b1, enc_r(7'd0, 5'd0, 5'd0, 5'd14), 32'h508);
    q.push_back(mk("x0_during_wb", 64'h508, '0, '0, '0, 5'd0, 5'd0, 5'd14, 4'h0, 2'b10, C_R, 1'b0));
    tick();
    set_wb(1'b0, '0, '0);
    drive(1'b1, enc_r(7'd0, 5'd0, 5'd0, 5'd15), 32'h50C);
    q.push_back(mk("x0_after_wb", 64'h50C, '0, '0, '0, 5'd0, 5'd0, 5'd15, 4'h0, 2'b10, C_R, 1'b0));
    tick();
  endtask

  task automatic test_illegal();
    drive(1'b1, {7'd0, 5'd2, 5'd1, 3'b000, 5'd4, 7'b1111111}, 32'h600);
    q.push_back(mk("illegal", 64'h600, 64'h100, 64'h22, '0, 5'd1, 5'd2, 5'd4, 4'h0, 2'b00, C_ILL, 1'b0));
    tick();
    drive(1'b0, '0, '0);
    q.push_back(bubble("ill_cleared", 1'b0));
    tick();
    drive(1'b1, {20'h80000, 5'd3, 7'b0110111}, 32'h604);
    #1;
    vectors++;
    if (h64 !== 1'b0) begin
      miscompares++;
      $display("FAIL lui64_stall hazard_stall: got %b want 0", h64);
    end
    q.push_back(mk("lui_80000", 64'h604, '0, '0, 64'h80000000, 5'd0, 5'd0, 5'd3, 4'h0, 2'b00, C_LUI, 1'b1));
    q64.push_back(mk("lui_80000_64", 64'h604, '0, '0, 64'hFFFFFFFF80000000, 5'd0, 5'd0, 5'd3, 4'h0,
                     2'b00, C_LUI, 1'b1));
    tick();
    drive(1'b0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_add();
    test_load_use();
    test_branch_flush();
    test_bypass();
    test_illegal();
    tick();
    tick();
    vectors++;
    if ((q.size() + q64.size()) != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d pending want 0", q.size() + q64.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
